fifo_rd_ptr_empty: RTL and testbench
====================================

// Module: fifo_rd_ptr_empty
// PURPOSE
//   Read-domain pointer/flag controller for the async FIFO. Synchronises the write
//   pointer (Gray) into the read clock domain, converts it to binary with gray2bin,
//   and maintains the read pointer, memory read address, empty flag and occupancy.
//   Sits between the dual-port RAM read port and the read-side consumer.
// PARAMETERS
//   ADDR_WIDTH   4   RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//   SYNC_STAGES  2   flops in the write-pointer synchroniser chain (>= 2)
// PORTS
//   clk              in   1             read-domain clock; all logic on rising edge
//   rst              in   1             synchronous, active-high reset
//   rd_en            in   1             consumer read request
//   wptr_gray_async  in   ADDR_WIDTH+1  write pointer (Gray), write clock domain
//   rd_addr          out  ADDR_WIDTH    RAM read address = rbin[ADDR_WIDTH-1:0]
//   rptr_gray        out  ADDR_WIDTH+1  registered Gray read pointer, to write domain
//   empty            out  1             registered; 1 = no readable entry
//   rd_valid         out  1             RAM read data valid (1 cycle after accepted read)
//   rd_count         out  ADDR_WIDTH+1  registered occupancy seen by read side, 0..depth
//   underflow        out  1             1-cycle pulse: rd_en asserted while empty
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): sync chain, rbin, rptr_gray, rd_valid, underflow,
//     rd_count -> 0; empty -> 1. Write side must be reset in the same window.
//   - Synchroniser: wq[0] <= wptr_gray_async; wq[k] <= wq[k-1]; wq_sync = wq[SYNC_STAGES-1].
//     Only Gray values cross; no combinational logic before wq[0].
//   - gray2bin(WIDTH=ADDR_WIDTH+1) converts wq_sync -> wbin_sync (combinational).
//   - accept = rd_en & ~empty. rbin_next = rbin + accept, modulo 2**(ADDR_WIDTH+1).
//   - rgray_next = rbin_next ^ (rbin_next >> 1); rptr_gray <= rgray_next.
//   - empty <= (rgray_next == wq_sync)  (full-width compare, wrap bit included).
//   - rd_count <= wbin_sync - rbin_next, modulo 2**(ADDR_WIDTH+1); never exceeds depth.
//   - rd_addr is rbin[ADDR_WIDTH-1:0] (registered pointer); RAM is synchronous
//     read, so rd_valid <= accept and data is valid on the cycle rd_valid=1.
//   - rd_en while empty: no pointer move, rd_valid=0 next cycle, underflow=1 next cycle.
//   - Latency: write-pointer change -> empty deassert = SYNC_STAGES+1 clk edges.
//   - Last entry read: empty asserts on the same edge rbin advances (no extra read).
//   - Wrap: rbin 2**(ADDR_WIDTH+1)-1 -> 0; rd_addr wraps depth-1 -> 0; Gray step is
//     single-bit. Empty compare uses MSB so full (ptrs differ only in MSB pair) is not empty.
//   - Simultaneous rd_en and incoming write update: read accepted per current empty;
//     new entry reflected in empty/rd_count the following cycle.
//   - Reset mid-operation overrides rd_en; in-flight rd_valid is dropped.
//   - empty is pessimistic (may stay 1 briefly after a write); never falsely 0.
// STRUCTURE
//   - Package fifo_pkg: ADDR_WIDTH default, localparam PTR_W = ADDR_WIDTH+1,
//     function bin2gray(PTR_W), typedef ptr_t [PTR_W-1:0].
//   - One sub-module instance: gray2bin (WIDTH=PTR_W) on wq_sync.
//   - Sync chain kept as a plain generate loop in this module (ASYNC_REG attr on wq).
// TESTING  (ADDR_WIDTH=4, SYNC_STAGES=2)
//   - Reset: rst=1 2 cycles, wptr_gray_async=0 -> empty=1, rd_count=0, rptr_gray=0,
//     rd_valid=0, underflow=0.
//   - Write visibility: wptr_gray_async 0->1 (bin 1) at cycle 0 -> empty=0, rd_count=1
//     after exactly 3 clk edges.
//   - Drain: wptr bin 3 (Gray 2), rd_en held 4 cycles -> 3 rd_valid pulses, rd_addr 0,1,2,
//     empty=1 on edge of 3rd accept, 4th rd_en -> underflow pulse, rbin stays 3.
//   - Wrap: preload rbin near 31 by 40 write/read pairs -> rd_addr 15->0, rptr_gray
//     changes one bit per step, rbin 31->0, empty correct throughout.
//   - Full depth: wptr bin 16 (Gray 24) with rbin=0 -> empty=0, rd_count=16; read 16 -> empty=1.
//   - Reset mid-operation: rst=1 while rd_en=1 and rd_count=5 -> next edge all outputs at
//     reset values, no rd_valid pulse.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default geometry, pointer type and Gray encoding.
// Both clock domains import this so pointer widths stay in lockstep.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int PTR_W           = DEF_ADDR_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter for a synchronised FIFO pointer.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer/flag controller: synchronises the Gray write pointer, advances the
// read pointer on accepted reads, and produces empty, occupancy, read-valid and underflow.
module fifo_rd_ptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    (* ASYNC_REG = "TRUE" *) logic [PW-1:0] wq_q [SYNC_STAGES];
    logic [PW-1:0] wq_d [SYNC_STAGES];
    logic [PW-1:0] wq_sync;
    logic [PW-1:0] wbin_sync;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] rd_count_q, rd_count_d;
    logic          empty_q, empty_d;
    logic          rd_valid_q, rd_valid_d;
    logic          underflow_q, underflow_d;
    logic          accept;

    // Only registered Gray values enter the chain, so at most one bit can be in flight.
    always_comb begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
            wq_d[k] = (k == 0) ? wptr_gray_async : wq_q[(k == 0) ? 0 : k - 1];
        end
    end

    for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                wq_q[k] <= '0;
            end else begin
                wq_q[k] <= wq_d[k];
            end
        end
    end

    assign wq_sync = wq_q[SYNC_STAGES-1];

    gray2bin #(
        .WIDTH (PW)
    ) u_gray2bin (
        .gray (wq_sync),
        .bin  (wbin_sync)
    );

    // Flags are computed from the post-read pointer so the last read sets empty on the same edge.
    always_comb begin
        accept      = rd_en & ~empty_q;
        rbin_d      = rbin_q + {{(PW-1){1'b0}}, accept};
        rgray_d     = rbin_d ^ (rbin_d >> 1);
        empty_d     = (rgray_d == wq_sync);
        rd_count_d  = wbin_sync - rbin_d;
        rd_valid_d  = accept;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rd_count_q  <= '0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rd_count_q  <= rd_count_d;
            empty_q     <= empty_d;
            rd_valid_q  <= rd_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_addr   = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray = rgray_q;
    assign empty     = empty_q;
    assign rd_valid  = rd_valid_q;
    assign rd_count  = rd_count_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Directed + randomized bench for fifo_rd_ptr_empty against an unbounded-integer occupancy model.
module tb_fifo_rd_ptr_empty;

    localparam int AW = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW:0]   wptr_gray_async = '0;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rptr_gray;
    logic          empty;
    logic          rd_valid;
    logic [AW:0]   rd_count;
    logic          underflow;

    fifo_rd_ptr_empty #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wptr_gray_async (wptr_gray_async),
        .rd_addr         (rd_addr),
        .rptr_gray       (rptr_gray),
        .empty           (empty),
        .rd_valid        (rd_valid),
        .rd_count        (rd_count),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    // Model: total entries written / read as plain integers; writes become visible SS+1 edges later.
    int   writes_total;
    int   reads_total;
    int   vis_pipe [SS];
    int   m_count;
    bit   m_empty;
    bit   m_valid;
    bit   m_under;
    int   vectors;
    int   miscompares;
    logic [AW:0] prev_gray;

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge(input bit en, input bit r);
        int visible;
        if (r) begin
            reads_total = 0;
            for (int k = 0; k < SS; k++) vis_pipe[k] = 0;
            m_count = 0;
            m_empty = 1'b1;
            m_valid = 1'b0;
            m_under = 1'b0;
        end else begin
            visible = vis_pipe[SS-1];
            m_valid = en && !m_empty;
            m_under = en && m_empty;
            if (m_valid) reads_total++;
            m_count = visible - reads_total;
            m_empty = (m_count == 0);
            for (int k = SS - 1; k > 0; k--) vis_pipe[k] = vis_pipe[k-1];
            vis_pipe[0] = writes_total;
        end
    endtask

    task automatic step(input bit en, input bit r);
        int exp_addr;
        logic [AW:0] exp_gray;
        logic [AW:0] exp_cnt;
        @(negedge clk);
        rd_en = en;
        rst = r;
        wptr_gray_async = to_gray(writes_total);
        prev_gray = rptr_gray;
        @(posedge clk);
        model_edge(en, r);
        #1;
        exp_addr = reads_total % (1 << AW);
        exp_gray = to_gray(reads_total);
        exp_cnt  = m_count[AW:0];
        vectors++;
        assert (empty === m_empty) else begin
            miscompares++;
            $error("[TB] FAIL empty got %b want %b (rd=%0d wr=%0d)", empty, m_empty, reads_total, writes_total);
        end
        assert (rd_count === exp_cnt) else begin
            miscompares++;
            $error("[TB] FAIL rd_count got %0d want %0d", rd_count, exp_cnt);
        end
        assert (rd_addr === exp_addr[AW-1:0]) else begin
            miscompares++;
            $error("[TB] FAIL rd_addr got %0d want %0d", rd_addr, exp_addr);
        end
        assert (rptr_gray === exp_gray) else begin
            miscompares++;
            $error("[TB] FAIL rptr_gray got %b want %b", rptr_gray, exp_gray);
        end
        assert (rd_valid === m_valid) else begin
            miscompares++;
            $error("[TB] FAIL rd_valid got %b want %b", rd_valid, m_valid);
        end
        assert (underflow === m_under) else begin
            miscompares++;
            $error("[TB] FAIL underflow got %b want %b", underflow, m_under);
        end
        assert ($countones(rptr_gray ^ prev_gray) <= 1 || r) else begin
            miscompares++;
            $error("[TB] FAIL gray_step got %b want one-bit change from %b", rptr_gray, prev_gray);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        writes_total = 0;
        reads_total  = 0;
        prev_gray    = '0;
        for (int k = 0; k < SS; k++) vis_pipe[k] = 0;
        m_count = 0;
        m_empty = 1'b1;
        m_valid = 1'b0;
        m_under = 1'b0;

        $display("[TB] reset");
        step(0, 1);
        step(0, 1);

        $display("[TB] write visibility latency");
        writes_total = 1;
        step(0, 0);
        step(0, 0);
        assert (empty === 1'b1) else begin
            miscompares++;
            $error("[TB] FAIL early_visible got empty=%b want 1", empty);
        end
        step(0, 0);
        assert (empty === 1'b0 && rd_count === 5'd1) else begin
            miscompares++;
            $error("[TB] FAIL latency got empty=%b count=%0d want 0/1", empty, rd_count);
        end

        $display("[TB] drain three entries plus one underflow");
        step(0, 1);
        step(0, 1);
        writes_total = 3;
        for (int i = 0; i < 3; i++) step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 0);

        $display("[TB] wrap via write/read pairs");
        for (int i = 0; i < 40; i++) begin
            writes_total++;
            step(1, 0);
        end
        for (int i = 0; i < 6; i++) step(1, 0);

        $display("[TB] full depth");
        writes_total = 0;
        step(0, 1);
        writes_total = 16;
        for (int i = 0; i < 3; i++) step(0, 0);
        for (int i = 0; i < 17; i++) step(1, 0);

        $display("[TB] reset mid-operation");
        writes_total = 0;
        step(0, 1);
        writes_total = 5;
        for (int i = 0; i < 3; i++) step(0, 0);
        writes_total = 0;
        step(1, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (writes_total - reads_total < 16 && ($urandom_range(0, 99) < 55))
                writes_total++;
            step(($urandom_range(0, 99) < 50), ($urandom_range(0, 199) == 0));
            if (rst) writes_total = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
